holy_axi_read_arbiter: RTL

HOLY_AXI_READ_ARBITER -- requirements
Module: holy_axi_read_arbiter

---
 rtl/holy_axi_read_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/holy_axi_read_arbiter.sv
// Two-requester AXI read-address/read-data arbiter (icache = 0, dcache = 1).
// Only one read is outstanding at a time; round-robin is used when both request together.
module holy_axi_read_arbiter (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [1:0]  s_arvalid,
  input  logic [63:0] s_araddr,
  input  logic [15:0] s_arlen,
  output logic [1:0]  s_arready,
  output logic [1:0]  s_rvalid,
  input  logic [1:0]  s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [3:0]  m_axi_rid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic        next_grant;
  logic [1:0]  grant_mask;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic        unused_rid;

  // On a tie the requester that did not win last time goes next.
  assign next_grant = (&s_arvalid) ? ~last_grant : s_arvalid[1];
  assign grant_mask = grant ? 2'b10 : 2'b01;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= 32'h0;
      len_q      <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_arvalid) begin
            grant  <= next_grant;
            addr_q <= next_grant ? s_araddr[63:32] : s_araddr[31:0];
            len_q  <= next_grant ? s_arlen[15:8] : s_arlen[7:0];
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) state <= DATA;
        end
        DATA: begin
          if (m_axi_rvalid && s_rready[grant] && m_axi_rlast) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_arid    = {3'b000, grant};
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;

  // Handshakes are steered only to the granted requester, and only in their own phase.
  assign s_arready    = (state == ADDR && m_axi_arready) ? grant_mask : 2'b00;
  assign s_rvalid     = (state == DATA && m_axi_rvalid) ? grant_mask : 2'b00;
  assign m_axi_rready = (state == DATA) && s_rready[grant];

  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_rlast = m_axi_rlast;

  // Routing never depends on the returned ID since only one read is in flight.
  assign unused_rid = ^m_axi_rid;

endmodule
